// File: rtl/arcade_input_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : arcade_input_mux                                           |
// | Description : Merges a PS/2 keyboard and per-player joystick inputs into |
// |               registered arcade controls. Supports an optional 90-degree |
// |               direction remap, shaped coin pulses with lockout, and      |
// |               optional autofire on button 0.                             |
// | Option      : ARCADE_INPUT_AUTOFIRE_EN - when defined, autofire on B0.   |
// | Ports       : clk_sys    - system clock, all state on rising edge        |
// |               reset_n    - asynchronous active-low reset                 |
// |               ps2_key    - [10] toggle, [9] pressed, [8] ext, [7:0] code |
// |               joy_in     - 16 bits/player: R,L,D,U,B0..B3,start,coin     |
// |               rotate     - 1 = 90-degree direction remap                 |
// |               clear      - synchronous clear of keyboard latches         |
// |               autofire   - autofire enable for button 0                  |
// |               p_dir      - 4 bits/player {up,down,left,right}            |
// |               p_btn      - BUTTONS bits/player action buttons            |
// |               p_start    - start button per player                       |
// |               coin_pulse - shaped coin pulse per player                  |
// |               key_event  - one-cycle strobe per accepted keyboard event  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module arcade_input_mux #(
    parameter int PLAYERS        = 2,
    parameter int BUTTONS        = 2,
    parameter int COIN_PULSE_CYC = 1600000,
    parameter int COIN_LOCK_CYC  = 3200000,
    parameter int AUTOFIRE_HALF  = 400000
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic [10:0]                ps2_key,
    input  logic [16*PLAYERS-1:0]      joy_in,
    input  logic                       rotate,
    input  logic                       clear,
    input  logic                       autofire,
    output logic [4*PLAYERS-1:0]       p_dir,
    output logic [BUTTONS*PLAYERS-1:0] p_btn,
    output logic [PLAYERS-1:0]         p_start,
    output logic [PLAYERS-1:0]         coin_pulse,
    output logic                       key_event
);

    // Keyboard latches use the joy_in bit layout (10 used bits per player)
    localparam int c_nfunc = 10;
    localparam int c_cnt_max = (COIN_PULSE_CYC > COIN_LOCK_CYC) ? COIN_PULSE_CYC : COIN_LOCK_CYC;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam logic [c_cnt_w-1:0] c_pulse_last = c_cnt_w'(COIN_PULSE_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_lock_last  = c_cnt_w'((COIN_LOCK_CYC > 0) ? COIN_LOCK_CYC - 1 : 0);
    localparam logic [c_cnt_w-1:0] c_cnt_inc    = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_LOCK  = 2'd2
    } coin_state_t;

    // ------------------------------------------------------------------
    // Keyboard event decode and latches
    // ------------------------------------------------------------------
    logic                       toggle_q;
    logic                       armed_q;   // low only in the first cycle after reset
    logic                       key_event_q;
    logic [c_nfunc*PLAYERS-1:0] kb_q;
    logic [c_nfunc*PLAYERS-1:0] kb_d;
    logic                       w_accept;
    logic                       w_hit;
    logic                       w_p2;
    logic [3:0]                 w_func;
    int                         w_idx;

    assign w_accept = armed_q && (ps2_key[10] != toggle_q);

    always_comb begin
        w_hit  = 1'b1;
        w_p2   = 1'b0;
        w_func = 4'd0;
        case (ps2_key[8:0])
            9'h175: w_func = 4'd3;
            9'h172: w_func = 4'd2;
            9'h16B: w_func = 4'd1;
            9'h174: w_func = 4'd0;
            9'h014: w_func = 4'd4;
            9'h011: w_func = 4'd5;
            9'h029: w_func = 4'd6;
            9'h012: w_func = 4'd7;
            9'h016: w_func = 4'd8;
            9'h02E: w_func = 4'd9;
            9'h02D: begin w_p2 = 1'b1; w_func = 4'd3; end
            9'h02B: begin w_p2 = 1'b1; w_func = 4'd2; end
            9'h023: begin w_p2 = 1'b1; w_func = 4'd1; end
            9'h034: begin w_p2 = 1'b1; w_func = 4'd0; end
            9'h01C: begin w_p2 = 1'b1; w_func = 4'd4; end
            9'h01B: begin w_p2 = 1'b1; w_func = 4'd5; end
            9'h015: begin w_p2 = 1'b1; w_func = 4'd6; end
            9'h01D: begin w_p2 = 1'b1; w_func = 4'd7; end
            9'h01E: begin w_p2 = 1'b1; w_func = 4'd8; end
            9'h036: begin w_p2 = 1'b1; w_func = 4'd9; end
            default: w_hit = 1'b0;
        endcase
        // Player 2 keys are dead on a single-player build
        if (w_p2 && (PLAYERS < 2)) begin
            w_hit = 1'b0;
        end
        w_idx = (w_p2 ? c_nfunc : 0) + int'(w_func);
    end

    // Clear takes priority over a simultaneous key event
    always_comb begin
        kb_d = kb_q;
        if (clear) begin
            kb_d = '0;
        end else if (w_accept && w_hit) begin
            for (int i = 0; i < c_nfunc * PLAYERS; i++) begin
                if (i == w_idx) begin
                    kb_d[i] = ps2_key[9];
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            toggle_q    <= 1'b0;
            armed_q     <= 1'b0;
            key_event_q <= 1'b0;
            kb_q        <= '0;
        end else begin
            toggle_q    <= ps2_key[10];
            armed_q     <= 1'b1;
            key_event_q <= w_accept;
            kb_q        <= kb_d;
        end
    end

    assign key_event = key_event_q;

    // ------------------------------------------------------------------
    // Per-player merge, remap, autofire and coin shaping
    // ------------------------------------------------------------------
    logic [4*PLAYERS-1:0]       w_dir_all;
    logic [BUTTONS*PLAYERS-1:0] w_btn_all;
    logic [PLAYERS-1:0]         w_start_all;
    logic [6*PLAYERS-1:0]       w_unused_joy;

`ifndef ARCADE_INPUT_AUTOFIRE_EN
    logic [31:0] w_unused_af;
    assign w_unused_af = {autofire, 31'(AUTOFIRE_HALF)};
`endif

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [c_nfunc-1:0] w_raw;
        logic               w_unused_raw;
        logic               w_b0;

        assign w_raw        = kb_q[p*c_nfunc +: c_nfunc] | joy_in[p*16 +: c_nfunc];
        assign w_unused_raw = ^w_raw;
        assign w_unused_joy[p*6 +: 6] = joy_in[p*16 + c_nfunc +: 6];

        // Raw layout is {..,U,D,L,R}; rotated: up<-L, down<-R, left<-D, right<-U
        assign w_dir_all[p*4 +: 4] = rotate ? {w_raw[1], w_raw[0], w_raw[2], w_raw[3]}
                                            : {w_raw[3], w_raw[2], w_raw[1], w_raw[0]};
        assign w_start_all[p] = w_raw[8];

`ifdef ARCADE_INPUT_AUTOFIRE_EN
        localparam int c_af_w = (AUTOFIRE_HALF > 1) ? $clog2(AUTOFIRE_HALF) : 1;
        localparam logic [c_af_w-1:0] c_af_last = c_af_w'(AUTOFIRE_HALF - 1);
        localparam logic [c_af_w-1:0] c_af_inc  = c_af_w'(1);

        logic [c_af_w-1:0] af_cnt_q;
        logic [c_af_w-1:0] af_cnt_d;
        logic              af_phase_q;  // 0 = on half, 1 = off half
        logic              af_phase_d;

        always_comb begin
            af_cnt_d   = '0;
            af_phase_d = 1'b0;
            w_b0       = w_raw[4];
            if (autofire && w_raw[4]) begin
                w_b0 = ~af_phase_q;
                if (af_cnt_q == c_af_last) begin
                    af_phase_d = ~af_phase_q;
                end else begin
                    af_cnt_d   = af_cnt_q + c_af_inc;
                    af_phase_d = af_phase_q;
                end
            end
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                af_cnt_q   <= '0;
                af_phase_q <= 1'b0;
            end else begin
                af_cnt_q   <= af_cnt_d;
                af_phase_q <= af_phase_d;
            end
        end
`else
        assign w_b0 = w_raw[4];
`endif

        for (genvar b = 0; b < BUTTONS; b++) begin : g_btn
            if (b == 0) begin : g_b0
                assign w_btn_all[p*BUTTONS] = w_b0;
            end else begin : g_bn
                assign w_btn_all[p*BUTTONS + b] = w_raw[4 + b];
            end
        end

        // Coin: raw is registered once more, so the edge seen by the FSM
        // lands the pulse two cycles after the raw rise. Both history bits
        // reset high so a coin held through reset never counts as an edge.
        coin_state_t        coin_st_q;
        coin_state_t        coin_st_d;
        logic [c_cnt_w-1:0] coin_cnt_q;
        logic [c_cnt_w-1:0] coin_cnt_d;
        logic               coin_raw_q;
        logic               coin_prev_q;

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                coin_st_q   <= ST_IDLE;
                coin_cnt_q  <= '0;
                coin_raw_q  <= 1'b1;
                coin_prev_q <= 1'b1;
            end else begin
                coin_st_q   <= coin_st_d;
                coin_cnt_q  <= coin_cnt_d;
                coin_raw_q  <= w_raw[9];
                coin_prev_q <= coin_raw_q;
            end
        end

        always_comb begin
            coin_st_d  = coin_st_q;
            coin_cnt_d = '0;
            case (coin_st_q)
                ST_IDLE: begin
                    if (coin_raw_q && !coin_prev_q) begin
                        coin_st_d = ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (coin_cnt_q == c_pulse_last) begin
                        coin_st_d = (COIN_LOCK_CYC == 0) ? ST_IDLE : ST_LOCK;
                    end else begin
                        coin_cnt_d = coin_cnt_q + c_cnt_inc;
                    end
                end
                ST_LOCK: begin
                    if (coin_cnt_q == c_lock_last) begin
                        coin_st_d = ST_IDLE;
                    end else begin
                        coin_cnt_d = coin_cnt_q + c_cnt_inc;
                    end
                end
                default: coin_st_d = ST_IDLE;
            endcase
        end

        assign coin_pulse[p] = (coin_st_q == ST_PULSE);
    end

    // ------------------------------------------------------------------
    // Registered control outputs
    // ------------------------------------------------------------------
    logic [4*PLAYERS-1:0]       p_dir_q;
    logic [BUTTONS*PLAYERS-1:0] p_btn_q;
    logic [PLAYERS-1:0]         p_start_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            p_dir_q   <= '0;
            p_btn_q   <= '0;
            p_start_q <= '0;
        end else begin
            p_dir_q   <= w_dir_all;
            p_btn_q   <= w_btn_all;
            p_start_q <= w_start_all;
        end
    end

    assign p_dir   = p_dir_q;
    assign p_btn   = p_btn_q;
    assign p_start = p_start_q;

endmodule
`default_nettype wire

// File: tb/tb_arcade_input_mux.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_arcade_input_mux                                        |
// | Description : Randomised scoreboard bench for arcade_input_mux with a    |
// |               time-based reference model (keyboard state, remap, coin    |
// |               pulse windows, autofire phase from hold length).           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_arcade_input_mux;

    localparam int PLAYERS = 2;
    localparam int BUTTONS = 4;
    localparam int PULSE   = 4;
    localparam int LOCK    = 6;
    localparam int AF_HALF = 3;

    logic        clk_sys  = 1'b0;
    logic        reset_n  = 1'b0;
    logic [10:0] ps2_key  = '0;
    logic [31:0] joy_in   = '0;
    logic        rotate   = 1'b0;
    logic        clear    = 1'b0;
    logic        autofire = 1'b0;
    logic [7:0]  p_dir;
    logic [7:0]  p_btn;
    logic [1:0]  p_start;
    logic [1:0]  coin_pulse;
    logic        key_event;

    always #5 clk_sys = ~clk_sys;

    arcade_input_mux #(
        .PLAYERS       (PLAYERS),
        .BUTTONS       (BUTTONS),
        .COIN_PULSE_CYC(PULSE),
        .COIN_LOCK_CYC (LOCK),
        .AUTOFIRE_HALF (AF_HALF)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_key   (ps2_key),
        .joy_in    (joy_in),
        .rotate    (rotate),
        .clear     (clear),
        .autofire  (autofire),
        .p_dir     (p_dir),
        .p_btn     (p_btn),
        .p_start   (p_start),
        .coin_pulse(coin_pulse),
        .key_event (key_event)
    );

    typedef struct packed {
        logic [7:0] dir;
        logic [7:0] btn;
        logic [1:0] start;
        logic [1:0] coin;
        logic       kev;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_x;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Functions per player: up, down, left, right, B0..B3, start, coin
    logic [8:0] keymap [20] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h014, 9'h011, 9'h029, 9'h012, 9'h016, 9'h02E,
                                9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C, 9'h01B, 9'h015, 9'h01D, 9'h01E, 9'h036};
    int fbit [10] = '{3, 2, 1, 0, 4, 5, 6, 7, 8, 9};

    // Reference model state
    bit m_kb [2][10];
    bit m_armed;
    bit m_tog;
    bit m_h1 [2];
    bit m_h2 [2];
    int m_edge;
    int m_free [2];
    int m_pstart [2];
    int m_af_n [2];

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            for (int f = 0; f < 10; f++) m_kb[p][f] = 1'b0;
            m_h1[p]     = 1'b1;
            m_h2[p]     = 1'b1;
            m_free[p]   = 0;
            m_pstart[p] = -1000;
            m_af_n[p]   = 0;
        end
        m_armed = 1'b0;
        m_tog   = 1'b0;
        m_edge  = 0;
    endtask

    // Predicts the outputs after the coming rising edge from the inputs now applied
    task automatic model_step();
        exp_t x;
        bit   raw [10];
        bit   u, d, l, r, acc;
        x = '0;
        m_edge++;
        for (int p = 0; p < PLAYERS; p++) begin
            for (int f = 0; f < 10; f++) raw[f] = m_kb[p][f] | joy_in[p*16 + fbit[f]];
            u = raw[0]; d = raw[1]; l = raw[2]; r = raw[3];
            if (rotate) begin
                u = raw[2]; d = raw[3]; l = raw[1]; r = raw[0];
            end
            x.dir[p*4 + 3] = u;
            x.dir[p*4 + 2] = d;
            x.dir[p*4 + 1] = l;
            x.dir[p*4 + 0] = r;
            for (int b = 0; b < BUTTONS; b++) x.btn[p*BUTTONS + b] = raw[4 + b];
`ifdef ARCADE_INPUT_AUTOFIRE_EN
            if (autofire && raw[4]) begin
                x.btn[p*BUTTONS] = ((m_af_n[p] / AF_HALF) % 2) == 0;
                m_af_n[p]++;
            end else begin
                m_af_n[p] = 0;
            end
`endif
            x.start[p] = raw[8];
            if (m_edge >= m_free[p] && m_h1[p] && !m_h2[p]) begin
                m_pstart[p] = m_edge;
                m_free[p]   = m_edge + PULSE + LOCK + 1;
            end
            x.coin[p] = (m_edge - m_pstart[p]) < PULSE;
            m_h2[p] = m_h1[p];
            m_h1[p] = raw[9];
        end
        acc     = m_armed && (ps2_key[10] != m_tog);
        x.kev   = acc;
        m_tog   = ps2_key[10];
        m_armed = 1'b1;
        if (clear) begin
            for (int p = 0; p < 2; p++)
                for (int f = 0; f < 10; f++) m_kb[p][f] = 1'b0;
        end else if (acc) begin
            for (int k = 0; k < 20; k++)
                if (keymap[k] == ps2_key[8:0]) m_kb[k / 10][k % 10] = ps2_key[9];
        end
        exp_q.push_back(x);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk_sys);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic key(input logic pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
    endtask

    // Monitor: compares every cycle for which an expectation was queued
    initial begin
        forever begin
            @(posedge clk_sys);
            #2;
            if (exp_q.size() > 0) begin
                mon_x = exp_q.pop_front();
                check("p_dir",      p_dir,             mon_x.dir);
                check("p_btn",      p_btn,             mon_x.btn);
                check("p_start",    8'(p_start),       8'(mon_x.start));
                check("coin_pulse", 8'(coin_pulse),    8'(mon_x.coin));
                check("key_event",  8'(key_event),     8'(mon_x.kev));
            end
        end
    end

    initial begin
        logic [8:0] code;
        int         kv;
        model_reset();
        repeat (3) @(negedge clk_sys);
        check("rst_dir",   p_dir,          8'h00);
        check("rst_btn",   p_btn,          8'h00);
        check("rst_start", 8'(p_start),    8'h00);
        check("rst_coin",  8'(coin_pulse), 8'h00);
        check("rst_kev",   8'(key_event),  8'h00);
        reset_n = 1'b1;
        tick();

        // Keyboard P1 up press and release
        ps2_key = 11'h775;
        ticks(3);
        ps2_key = 11'h175;
        ticks(3);

        // Rotated joystick left becomes up
        rotate = 1'b1; joy_in[1] = 1'b1;
        ticks(2);
        rotate = 1'b0; joy_in[1] = 1'b0;
        tick();

        // Coin held 20 cycles, re-press during lockout, re-press after lockout
        joy_in[9] = 1'b1; ticks(20);
        joy_in[9] = 1'b0; ticks(3);
        joy_in[9] = 1'b1; ticks(2);
        joy_in[9] = 1'b0; ticks(4);
        joy_in[9] = 1'b1; ticks(2);
        joy_in[9] = 1'b0; ticks(12);
        joy_in[9] = 1'b1; ticks(2);
        joy_in[9] = 1'b0; ticks(14);

        // Asynchronous reset in the middle of a pulse, coin held through it
        joy_in[9] = 1'b1; ticks(3);
        reset_n = 1'b0;
        #1;
        check("async_coin",  8'(coin_pulse), 8'h00);
        check("async_dir",   p_dir,          8'h00);
        check("async_btn",   p_btn,          8'h00);
        check("async_start", 8'(p_start),    8'h00);
        check("async_kev",   8'(key_event),  8'h00);
        repeat (2) @(negedge clk_sys);
        ps2_key = 11'h400;
        model_reset();
        reset_n = 1'b1;
        ticks(15);
        joy_in[9] = 1'b0; ticks(2);
        joy_in[9] = 1'b1; ticks(8);
        joy_in[9] = 1'b0; ticks(12);

        // Autofire on P1 button 0
        autofire = 1'b1; joy_in[4] = 1'b1;
        ticks(12);
        joy_in[4] = 1'b0; ticks(2);
        autofire = 1'b0;

        // Clear wins over a simultaneous key event
        key(1'b1, 9'h014); ticks(2);
        key(1'b1, 9'h01C); clear = 1'b1; tick();
        clear = 1'b0; ticks(2);
        key(1'b1, 9'h02E); ticks(3);
        key(1'b0, 9'h02E); ticks(14);

        // Randomised traffic
        for (int c = 0; c < 2500; c++) begin
            for (int b = 0; b < 32; b++)
                if ($urandom_range(0, 15) == 0) joy_in[b] = ~joy_in[b];
            if ($urandom_range(0, 3) == 0) begin
                kv = $urandom_range(0, 27);
                code = (kv < 20) ? keymap[kv] : 9'($urandom_range(0, 511));
                key(1'($urandom_range(0, 1)), code);
            end
            if ($urandom_range(0, 63) == 0) rotate = ~rotate;
            if ($urandom_range(0, 63) == 0) autofire = ~autofire;
            clear = ($urandom_range(0, 31) == 0);
            tick();
        end
        clear = 1'b0;
        ticks(3);
        repeat (2) @(negedge clk_sys);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
